// File: rtl/usb_tx_encoder.sv
// USB FS transmitter: SYNC/PID/payload/CRC16 LSB-first, bit stuffing, NRZI, EOP; `USB_TX_CRC_EN adds CRC16 to DATA0.
// First bit on the wire one clk after the request; buffer popped one clk ahead of each byte, requests while busy are dropped.
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 4,
   parameter int MAX_PAYLOAD  = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [1:0] tx_packet,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   output logic       tx_transfer_active,
   output logic       tx_error,
   output logic       dplus_out,
   output logic       dminus_out
);
   localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
   localparam logic [6:0]    MAX_OCC = 7'(MAX_PAYLOAD);
   localparam logic [1:0]    PKT_DATA0 = 2'd1;

   typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP} state_t;

   state_t        state, nxt_state;
   logic [1:0]    pid;
   logic [6:0]    byte_count;
   logic [7:0]    shreg, nxt_byte;
   logic [2:0]    bit_idx, ones_cnt;
   logic [1:0]    eop_cnt;
   logic [TW-1:0] timer;
   logic          line_j;
   logic          stuff, wrap, more_payload, nxt_bit;
   logic [3:0]    pid4;

`ifdef USB_TX_CRC_EN
   logic [15:0] crc;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      crc_step = {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
   endfunction
`endif

   assign stuff        = (ones_cnt == 3'd6);
   assign wrap         = (timer == T_LAST);
   assign more_payload = ((state == PID) || (state == DATA)) && (byte_count != 7'd0);
   assign pid4         = (pid == 2'd1) ? 4'b0011 : (pid == 2'd2) ? 4'b0010 : 4'b1010;
   assign nxt_bit      = nxt_byte[0];

   // Next byte/state at a byte boundary; within a byte just shift toward the LSB.
   always_comb begin
      nxt_state = state;
      nxt_byte  = {1'b0, shreg[7:1]};
      if (bit_idx == 3'd7) begin
         nxt_byte = 8'h00;
         case (state)
            SYNC: begin
               nxt_state = PID;
               nxt_byte  = {~pid4, pid4};
            end
            PID, DATA: begin
               if (more_payload) begin
                  nxt_state = DATA;
                  nxt_byte  = tx_packet_data;
               end
`ifdef USB_TX_CRC_EN
               else if (pid == PKT_DATA0) begin
                  nxt_state = CRC_LO;
                  nxt_byte  = ~crc[7:0];
               end
`endif
               else nxt_state = EOP;
            end
`ifdef USB_TX_CRC_EN
            CRC_LO: begin
               nxt_state = CRC_HI;
               nxt_byte  = ~crc[15:8];
            end
`endif
            default: nxt_state = EOP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state              <= IDLE;
         pid                <= 2'd0;
         byte_count         <= 7'd0;
         shreg              <= 8'h00;
         bit_idx            <= 3'd0;
         ones_cnt           <= 3'd0;
         eop_cnt            <= 2'd0;
         timer              <= '0;
         line_j             <= 1'b1;
         dplus_out          <= 1'b1;
         dminus_out         <= 1'b0;
         tx_transfer_active <= 1'b0;
         tx_error           <= 1'b0;
         get_tx_packet_data <= 1'b0;
`ifdef USB_TX_CRC_EN
         crc                <= 16'hFFFF;
`endif
      end else begin
         tx_error           <= (state != IDLE) && (tx_packet != 2'd0);
         // Pop one cycle before the byte boundary so the buffer advances on the load edge.
         get_tx_packet_data <= (state != IDLE) && (timer == T_PRE) && !stuff
                               && (bit_idx == 3'd7) && more_payload;
         if (state == IDLE) begin
            timer <= '0;
            if (tx_packet != 2'd0) begin
               if ((tx_packet == PKT_DATA0) && (buffer_occupancy > MAX_OCC)) begin
                  tx_error <= 1'b1;
               end else begin
                  state              <= SYNC;
                  pid                <= tx_packet;
                  byte_count         <= (tx_packet == PKT_DATA0) ? buffer_occupancy : 7'd0;
                  shreg              <= 8'h80;
                  bit_idx            <= 3'd0;
                  ones_cnt           <= 3'd0;
                  line_j             <= 1'b0;
                  dplus_out          <= 1'b0;
                  dminus_out         <= 1'b1;
                  tx_transfer_active <= 1'b1;
               end
            end
         end else begin
            timer <= wrap ? '0 : timer + 1'b1;
            if (wrap) begin
               if (state == EOP) begin
                  eop_cnt <= eop_cnt + 2'd1;
                  if (eop_cnt == 2'd1) begin
                     line_j     <= 1'b1;
                     dplus_out  <= 1'b1;
                     dminus_out <= 1'b0;
                  end else if (eop_cnt == 2'd2) begin
                     state              <= IDLE;
                     tx_transfer_active <= 1'b0;
                  end
               end else if (stuff) begin
                  ones_cnt   <= 3'd0;
                  line_j     <= ~line_j;
                  dplus_out  <= ~line_j;
                  dminus_out <= line_j;
               end else if (nxt_state == EOP) begin
                  state      <= EOP;
                  eop_cnt    <= 2'd0;
                  ones_cnt   <= 3'd0;
                  dplus_out  <= 1'b0;
                  dminus_out <= 1'b0;
`ifdef USB_TX_CRC_EN
                  crc        <= 16'hFFFF;
`endif
               end else begin
                  state    <= nxt_state;
                  shreg    <= nxt_byte;
                  bit_idx  <= bit_idx + 3'd1;
                  ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
                  if (!nxt_bit) begin
                     line_j     <= ~line_j;
                     dplus_out  <= ~line_j;
                     dminus_out <= line_j;
                  end
                  if ((nxt_state == DATA) && (bit_idx == 3'd7))
                     byte_count <= byte_count - 7'd1;
`ifdef USB_TX_CRC_EN
                  if (nxt_state == DATA)
                     crc <= crc_step(crc, nxt_bit);
`endif
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: drives requests and a TX buffer model, records D+/D- every clock
// and compares against hand-written line sequences or a stuffing/NRZI/CRC16 reference model.
`timescale 1ns/1ps
module tb_usb_tx_encoder;
   typedef logic [7:0] byte_q_t[$];
   typedef logic [1:0] sym_q_t[$];
   localparam logic [1:0] S_J = 2'b10, S_K = 2'b01, S_0 = 2'b00;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [1:0] tx_packet = 2'd0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic [7:0] tx_packet_data = 8'h00;
   logic       get_tx_packet_data, tx_transfer_active, tx_error, dplus_out, dminus_out;

   always #5 clk = ~clk;

   usb_tx_encoder dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .tx_packet          (tx_packet),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_packet_data (get_tx_packet_data),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error),
      .dplus_out          (dplus_out),
      .dminus_out         (dminus_out)
   );

   int      n_chk = 0, n_pass = 0;
   byte_q_t buf_q, pl;
   sym_q_t  got_sym, exp_sym;
   int      pops, errs, first_pop, idle_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic drive_buf();
      buffer_occupancy = 7'(buf_q.size());
      tx_packet_data   = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
   endtask

   task automatic exp_from_str(input string s);
      exp_sym.delete();
      for (int i = 0; i < s.len(); i++)
         exp_sym.push_back((s[i] == "J") ? S_J : (s[i] == "K") ? S_K : S_0);
   endtask

   function automatic logic [15:0] crc16_usb(input byte_q_t d);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (d[i]) begin
         c = c ^ {8'h00, d[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic byte_q_t data0_bytes(input byte_q_t p);
      byte_q_t     b;
      logic [15:0] c;
      b.push_back(8'h80);
      b.push_back(8'hC3);
      foreach (p[i]) b.push_back(p[i]);
`ifdef USB_TX_CRC_EN
      c = crc16_usb(p);
      b.push_back(c[7:0]);
      b.push_back(c[15:8]);
`else
      c = 16'h0000;
`endif
      return b;
   endfunction

   task automatic exp_from_bytes(input byte_q_t b);
      logic [1:0] lvl;
      int         ones;
      exp_sym.delete();
      lvl  = S_J;
      ones = 0;
      foreach (b[i]) begin
         for (int k = 0; k < 8; k++) begin
            if (!b[i][k]) lvl = ~lvl;
            exp_sym.push_back(lvl);
            ones = b[i][k] ? ones + 1 : 0;
            if (ones == 6) begin
               lvl = ~lvl;
               exp_sym.push_back(lvl);
               ones = 0;
            end
         end
      end
      exp_sym.push_back(S_0);
      exp_sym.push_back(S_0);
      exp_sym.push_back(S_J);
   endtask

   // One request pulse, then record the wire until tx_transfer_active drops, plus 8 idle clocks.
   task automatic send(input logic [1:0] typ, input int inject_at);
      int   cyc;
      logic pend;
      got_sym.delete();
      pops = 0; errs = 0; first_pop = -1; idle_bad = 0; pend = 1'b0;
      drive_buf();
      @(negedge clk); tx_packet = typ;
      @(negedge clk); tx_packet = 2'd0;
      cyc = 0;
      if (tx_error) errs++;
      while (tx_transfer_active && cyc < 4000) begin
         got_sym.push_back({dplus_out, dminus_out});
         if (get_tx_packet_data) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
         end
         if (pend) void'(buf_q.pop_front());
         pend = get_tx_packet_data;
         drive_buf();
         tx_packet = (cyc == inject_at) ? 2'd3 : 2'd0;
         @(negedge clk);
         cyc++;
         if (tx_error) errs++;
      end
      tx_packet = 2'd0;
      check("timeout", cyc < 4000, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tx_transfer_active || ({dplus_out, dminus_out} != S_J) || get_tx_packet_data) idle_bad++;
         if (tx_error) errs++;
      end
   endtask

   task automatic check_wire(input string tag);
      int mism;
      mism = 0;
      for (int i = 0; i < got_sym.size(); i++)
         if ((i / 4 >= exp_sym.size()) || (got_sym[i] !== exp_sym[i / 4])) mism++;
      check({tag, "_len"}, got_sym.size(), exp_sym.size() * 4);
      check({tag, "_wire"}, mism, 0);
      check({tag, "_idle"}, idle_bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_dplus", dplus_out, 1);
      check("rst_dminus", dminus_out, 0);
      check("rst_active", tx_transfer_active, 0);
      check("rst_error", tx_error, 0);
      check("rst_get", get_tx_packet_data, 0);
      @(negedge clk); n_rst = 1'b1;

      // Reset asserted in the middle of SYNC
      @(negedge clk); tx_packet = 2'd2;
      @(negedge clk); tx_packet = 2'd0;
      repeat (9) @(negedge clk);
      check("mid_active", tx_transfer_active, 1);
      #1 n_rst = 1'b0;
      #1;
      check("mid_rst_dplus", dplus_out, 1);
      check("mid_rst_dminus", dminus_out, 0);
      check("mid_rst_active", tx_transfer_active, 0);
      @(negedge clk); n_rst = 1'b1;

      exp_from_str("KJKJKJKKJJKJJKKK00J");
      send(2'd2, -1);
      check_wire("ack");
      check("ack_clks", got_sym.size(), 76);
      check("ack_pops", pops, 0);
      check("ack_err", errs, 0);

      exp_from_str("KJKJKJKKJJKKKJJK00J");
      send(2'd3, -1);
      check_wire("nak");

`ifdef USB_TX_CRC_EN
      exp_from_str("KJKJKJKKKKJKJKKKJKJKJKJKJKJKJKJK00J");
`else
      exp_from_str("KJKJKJKKKKJKJKKK00J");
`endif
      buf_q.delete();
      send(2'd1, -1);
      check_wire("zlp");
      check("zlp_pops", pops, 0);

      buf_q = {8'hFF, 8'hFF, 8'hFF, 8'h00};
      exp_from_bytes(data0_bytes(buf_q));
      send(2'd1, -1);
      check_wire("ones");
      check("ones_pops", pops, 4);
      check("ones_drained", buf_q.size(), 0);

      buf_q = {8'h12, 8'h34, 8'hA5};
      exp_from_bytes(data0_bytes(buf_q));
      send(2'd1, 80);
      check_wire("busy");
      check("busy_err", errs, 1);
      check("busy_pops", pops, 3);
      check("busy_first_pop", first_pop, 63);

      pl.delete();
      for (int i = 0; i < 64; i++) pl.push_back(8'(i * 37 + 5));
      buf_q = pl;
      exp_from_bytes(data0_bytes(pl));
      send(2'd1, -1);
      check_wire("max");
      check("max_pops", pops, 64);
      check("max_err", errs, 0);

      buf_q.delete();
      for (int i = 0; i < 65; i++) buf_q.push_back(8'h55);
      send(2'd1, -1);
      check("over_err", errs, 1);
      check("over_active_clks", got_sym.size(), 0);
      check("over_pops", pops, 0);
      check("over_idle", idle_bad, 0);
      buf_q.delete();
      drive_buf();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
